// File: rtl/shader_pkg.sv
// Shared definitions for the shader instruction sequencer and its executor:
// sequencer states, instruction width and the opcode field layout.
package shader_pkg;

    localparam int INSTR_W = 8;
    localparam logic [INSTR_W-1:0] NOP_INSTR = 8'h00;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        LOAD = 2'd2
    } seq_state_t;

    // Instruction layout: [7:6] major opcode; LDI carries a 6-bit immediate,
    // the ALU group splits the rest into function [5:3] and register [2:0].
    localparam int OPC_HI = 7;
    localparam int OPC_LO = 6;
    localparam int FN_HI  = 5;
    localparam int FN_LO  = 3;
    localparam int REG_HI = 2;
    localparam int REG_LO = 0;
    localparam int IMM_W  = 6;

    localparam logic [1:0] OPC_ALU    = 2'b00;
    localparam logic [1:0] OPC_LDI    = 2'b11;
    localparam logic [2:0] FN_SETRGB  = 3'b000;
    localparam logic [2:0] FN_CLEAR   = 3'b111;

    function automatic logic is_ldi(input logic [INSTR_W-1:0] instr);
        return instr[OPC_HI:OPC_LO] == OPC_LDI;
    endfunction

endpackage

// File: rtl/shader_prog_mem.sv
// Shader program storage: register array with one write port and one
// combinational read port; reset restores an all-NOP program.
module shader_prog_mem
    import shader_pkg::*;
#(
    parameter int NUM_INSTR = 16,
    parameter int PTR_W     = $clog2(NUM_INSTR)
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               i_we,
    input  logic [PTR_W-1:0]   i_waddr,
    input  logic [INSTR_W-1:0] i_wdata,
    input  logic [PTR_W-1:0]   i_raddr,
    output logic [INSTR_W-1:0] o_rdata
);

    logic [INSTR_W-1:0] r_mem [NUM_INSTR];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NUM_INSTR; i++) begin
                r_mem[i] <= NOP_INSTR;
            end
        end else if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/shader_sequencer.sv
// Streams the stored shader program to the executor once per pixel and
// accepts byte-wide program reloads from the host between pixels.
module shader_sequencer
    import shader_pkg::*;
#(
    parameter int NUM_INSTR = 16,
    parameter int PTR_W     = $clog2(NUM_INSTR)
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               pixel_start_i,
    input  logic               load_start_i,
    input  logic               wr_valid_i,
    input  logic [INSTR_W-1:0] wr_data_i,
    output logic               wr_ready_o,
    output logic [INSTR_W-1:0] instr_o,
    output logic               execute_o,
    output logic               done_o,
    output logic               load_done_o,
    output logic               busy_o,
    output logic               overrun_o
);

    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(NUM_INSTR - 1);

    seq_state_t         r_state;
    seq_state_t         w_state_nxt;
    logic [PTR_W-1:0]   r_rptr;
    logic [PTR_W-1:0]   w_rptr_nxt;
    logic [PTR_W-1:0]   r_wptr;
    logic [PTR_W-1:0]   w_wptr_nxt;
    logic               r_load_pending;
    logic               w_load_pending_nxt;
    logic               r_overrun;
    logic               w_overrun_nxt;

    logic               w_mem_we;
    logic [INSTR_W-1:0] w_rdata;
    logic               w_execute;
    logic [INSTR_W-1:0] w_instr;
    logic               w_done;
    logic               w_wr_ready;
    logic               w_load_done;

    shader_prog_mem #(
        .NUM_INSTR (NUM_INSTR),
        .PTR_W     (PTR_W)
    ) u_prog_mem (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .i_we    (w_mem_we),
        .i_waddr (r_wptr),
        .i_wdata (wr_data_i),
        .i_raddr (r_rptr),
        .o_rdata (w_rdata)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state        <= IDLE;
            r_rptr         <= '0;
            r_wptr         <= '0;
            r_load_pending <= 1'b0;
            r_overrun      <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_rptr         <= w_rptr_nxt;
            r_wptr         <= w_wptr_nxt;
            r_load_pending <= w_load_pending_nxt;
            r_overrun      <= w_overrun_nxt;
        end
    end

    always_comb begin
        w_state_nxt        = r_state;
        w_rptr_nxt         = r_rptr;
        w_wptr_nxt         = r_wptr;
        w_load_pending_nxt = r_load_pending;
        // Any pixel request outside IDLE (including the done cycle) is dropped.
        w_overrun_nxt      = r_overrun | (pixel_start_i && (r_state != IDLE));

        unique case (r_state)
            IDLE: begin
                if (pixel_start_i) begin
                    w_state_nxt = RUN;
                    w_rptr_nxt  = '0;
                    if (load_start_i) begin
                        w_load_pending_nxt = 1'b1;
                    end
                end else if (load_start_i || r_load_pending) begin
                    w_state_nxt        = LOAD;
                    w_wptr_nxt         = '0;
                    w_load_pending_nxt = 1'b0;
                end
            end
            RUN: begin
                w_rptr_nxt         = r_rptr + PTR_W'(1);
                w_load_pending_nxt = r_load_pending | load_start_i;
                if (r_rptr == LAST_PTR) begin
                    // A reload queued during the run starts straight after it.
                    if (r_load_pending) begin
                        w_state_nxt        = LOAD;
                        w_wptr_nxt         = '0;
                        w_load_pending_nxt = 1'b0;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end
            end
            LOAD: begin
                if (wr_valid_i) begin
                    w_wptr_nxt = r_wptr + PTR_W'(1);
                    if (r_wptr == LAST_PTR) begin
                        w_state_nxt = IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_comb begin
        w_execute   = 1'b0;
        w_instr     = NOP_INSTR;
        w_done      = 1'b0;
        w_wr_ready  = 1'b0;
        w_load_done = 1'b0;
        w_mem_we    = 1'b0;

        unique case (r_state)
            RUN: begin
                w_execute = 1'b1;
                w_instr   = w_rdata;
                w_done    = (r_rptr == LAST_PTR);
            end
            LOAD: begin
                w_wr_ready  = 1'b1;
                w_mem_we    = wr_valid_i;
                w_load_done = wr_valid_i && (r_wptr == LAST_PTR);
            end
            default: begin
            end
        endcase
    end

    assign execute_o   = w_execute;
    assign instr_o     = w_instr;
    assign done_o      = w_done;
    assign wr_ready_o  = w_wr_ready;
    assign load_done_o = w_load_done;
    assign busy_o      = (r_state != IDLE);
    assign overrun_o   = r_overrun;

endmodule

// File: tb/tb_shader_sequencer.sv
// Self-checking bench for shader_sequencer: directed scenarios plus random
// traffic, every cycle compared against a transaction-level reference model.
module tb_shader_sequencer;

    localparam int N = 16;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       pix, ls, wv;
    logic [7:0] wd;

    logic       wr_ready, execute, done, load_done, busy, overrun;
    logic [7:0] instr;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: position in the current run / load, -1 when not active.
    int         run_pos;
    int         load_pos;
    bit         pending;
    bit         ovr;
    logic [7:0] prog [N];

    always #5 clk = ~clk;

    shader_sequencer #(.NUM_INSTR(N)) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .pixel_start_i (pix),
        .load_start_i  (ls),
        .wr_valid_i    (wv),
        .wr_data_i     (wd),
        .wr_ready_o    (wr_ready),
        .instr_o       (instr),
        .execute_o     (execute),
        .done_o        (done),
        .load_done_o   (load_done),
        .busy_o        (busy),
        .overrun_o     (overrun)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    task automatic model_reset();
        run_pos  = -1;
        load_pos = -1;
        pending  = 0;
        ovr      = 0;
        for (int i = 0; i < N; i++) prog[i] = 8'h00;
    endtask

    task automatic check_outputs();
        bit         running, loading;
        logic [7:0] exp_instr;
        running   = (run_pos >= 0);
        loading   = (load_pos >= 0);
        exp_instr = running ? prog[run_pos] : 8'h00;
        check("execute",   execute,   running);
        check("instr",     instr,     exp_instr);
        check("done",      done,      running && run_pos == N - 1);
        check("wr_ready",  wr_ready,  loading);
        check("load_done", load_done, loading && wv && load_pos == N - 1);
        check("busy",      busy,      running || loading);
        check("overrun",   overrun,   ovr);
    endtask

    task automatic model_step();
        if (run_pos >= 0) begin
            if (pix) ovr = 1;
            if (run_pos == N - 1) begin
                run_pos = -1;
                if (pending) begin
                    load_pos = 0;
                    pending  = 0;
                end else if (ls) begin
                    pending = 1;
                end
            end else begin
                run_pos++;
                if (ls) pending = 1;
            end
        end else if (load_pos >= 0) begin
            if (pix) ovr = 1;
            if (wv) begin
                prog[load_pos] = wd;
                load_pos = (load_pos == N - 1) ? -1 : load_pos + 1;
            end
        end else begin
            if (pix) begin
                run_pos = 0;
                if (ls) pending = 1;
            end else if (ls || pending) begin
                load_pos = 0;
                pending  = 0;
            end
        end
    endtask

    // Entered and left just after a rising edge; inputs are already applied.
    task automatic cycle();
        @(negedge clk);
        check_outputs();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic p, input logic l, input logic v, input logic [7:0] d);
        pix = p;
        ls  = l;
        wv  = v;
        wd  = d;
        cycle();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 8'h00);
    endtask

    task automatic do_reset();
        pix   = 0;
        ls    = 0;
        wv    = 0;
        wd    = 8'h00;
        rst_n = 1'b0;
        model_reset();
        #2;
        check("rst_async_busy",    busy,    1'b0);
        check("rst_async_execute", execute, 1'b0);
        check("rst_async_overrun", overrun, 1'b0);
        cycle();
        rst_n = 1'b1;
    endtask

    // Feed bytes C0+i with random valid gaps until the model's load completes.
    task automatic load_program(input bit patterned);
        for (int t = 0; t < 400 && load_pos >= 0; t++) begin
            drive(0, 0, ($urandom % 3) != 0, patterned ? 8'hC0 + 8'(load_pos) : 8'($urandom));
        end
        check("load_finished", load_pos < 0, 1'b1);
    endtask

    initial begin
        pix   = 0;
        ls    = 0;
        wv    = 0;
        wd    = 8'h00;
        rst_n = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        do_reset();

        // Default program run
        drive(1, 0, 0, 8'h00);
        idle(20);

        // Reload with an incrementing pattern, then stream it
        drive(0, 1, 0, 8'h00);
        load_program(1);
        check("prog_first", prog[0], 8'hC0);
        check("prog_last",  prog[N-1], 8'hCF);
        drive(1, 0, 0, 8'h00);
        idle(20);

        // Simultaneous pixel and load: run with old program, then load
        drive(1, 1, 0, 8'h00);
        for (int i = 0; i < N; i++) drive(0, 0, 1, 8'h11);
        check("pending_load_entered", load_pos, 0);
        load_program(0);
        idle(2);

        // Overrun during a run, and a restart on the done cycle
        drive(1, 0, 0, 8'h00);
        for (int i = 1; i <= N; i++) drive(i == 5 || i == N, 0, 0, 8'h00);
        drive(1, 0, 0, 8'h00);
        idle(20);

        // Reset in the middle of a load
        drive(0, 1, 0, 8'h00);
        for (int i = 0; i < 7; i++) drive(0, 0, 1, 8'hC0 + 8'(i));
        do_reset();
        drive(1, 0, 0, 8'h00);
        idle(20);

        // Executor demo program, pixels spaced 17 clocks apart
        drive(0, 1, 0, 8'h00);
        for (int i = 0; i < N; i++) drive(0, 0, 1, (i == 0) ? 8'hFF : (i == 1) ? 8'h00 : 8'h39);
        for (int p = 0; p < 3; p++) begin
            drive(1, 0, 0, 8'h00);
            idle(N);
        end

        // Random traffic
        for (int i = 0; i < 4000; i++) begin
            if (($urandom % 700) == 0) begin
                do_reset();
            end else begin
                drive(($urandom % 12) == 0, ($urandom % 20) == 0,
                      ($urandom % 3) != 0, 8'($urandom));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
